// File: rtl/irq_controller.sv
// irq_controller: edge-capturing, maskable, fixed-priority interrupt controller
// with a request/ack/done handshake towards the CPU core.
// Optional build macro: IRQ_CONTROLLER_NMI_EN makes channel NUM_IRQ-1 a
// non-maskable, pre-empting interrupt with a 2-bit nesting depth counter.
module irq_controller #(
  parameter int NUM_IRQ     = 15,
  parameter int VECTOR_BASE = 1,
  parameter int VEC_W       = $clog2(NUM_IRQ + VECTOR_BASE)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clk_en,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_wr_en,
  input  logic [NUM_IRQ-1:0] mask_wr_data,
  input  logic               flag_clr_en,
  input  logic [NUM_IRQ-1:0] flag_clr_data,
  input  logic               global_enable,
  input  logic               irq_ack,
  input  logic               irq_done,
  output logic               irq_valid,
  output logic [VEC_W-1:0]   irq_vector,
  output logic [NUM_IRQ-1:0] flags,
  output logic [NUM_IRQ-1:0] mask,
  output logic               busy
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [NUM_IRQ-1:0] irq_in_q;
  logic [NUM_IRQ-1:0] set_vec;
  logic [NUM_IRQ-1:0] clr_vec;
  logic [NUM_IRQ-1:0] ack_clear;
  logic [NUM_IRQ-1:0] pend_req;
  logic [IDX_W-1:0]   sel, sel_nxt;
  logic [IDX_W-1:0]   winner;
  logic               latch;
  logic               sel_live;

`ifdef IRQ_CONTROLLER_NMI_EN
  localparam logic [IDX_W-1:0] NMI_IDX = IDX_W'(NUM_IRQ - 1);
  logic [1:0] depth, depth_nxt;
  logic       nmi_pend;
  logic       sel_is_nmi;
`endif

  // Rising-edge detection and the combined clear vector
  always_comb begin
    set_vec = irq_in & ~irq_in_q;
    clr_vec = (flag_clr_en ? flag_clr_data : '0) | ack_clear;
  end

  // Arbitration candidates; the NMI channel is handled outside the mask path
  always_comb begin
    pend_req = flags & mask;
`ifdef IRQ_CONTROLLER_NMI_EN
    pend_req[NUM_IRQ-1] = 1'b0;
    nmi_pend            = flags[NUM_IRQ-1];
    sel_is_nmi          = (sel == NMI_IDX);
    sel_live            = sel_is_nmi ? nmi_pend : (pend_req[sel] && global_enable);
`else
    sel_live            = pend_req[sel] && global_enable;
`endif
  end

  // Fixed-priority encoder: lowest pending index wins
  always_comb begin
    logic found;
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (pend_req[i] && !found) begin
        winner = IDX_W'(i);
        found  = 1'b1;
      end
    end
  end

  // Handshake FSM: next state, channel latch and ack auto-clear
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    latch     = 1'b0;
    ack_clear = '0;
`ifdef IRQ_CONTROLLER_NMI_EN
    depth_nxt = depth;
`endif
    case (state)
      IDLE: begin
`ifdef IRQ_CONTROLLER_NMI_EN
        if (nmi_pend) begin
          sel_nxt   = NMI_IDX;
          latch     = 1'b1;
          state_nxt = REQ;
        end else
`endif
        if (global_enable && (|pend_req)) begin
          sel_nxt   = winner;
          latch     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        // ack beats withdrawal when both happen in the same cycle
        if (irq_ack) begin
          ack_clear[sel] = 1'b1;
          state_nxt      = BUSY;
`ifdef IRQ_CONTROLLER_NMI_EN
          depth_nxt      = depth + 2'd1;
`endif
        end
`ifdef IRQ_CONTROLLER_NMI_EN
        else if (nmi_pend && !sel_is_nmi) begin
          sel_nxt = NMI_IDX;
          latch   = 1'b1;
        end else if (!sel_live) begin
          // a withdrawn nested request falls back to the interrupted handler
          state_nxt = (depth != 2'd0) ? BUSY : IDLE;
        end
`else
        else if (!sel_live) begin
          state_nxt = IDLE;
        end
`endif
      end
      BUSY: begin
`ifdef IRQ_CONTROLLER_NMI_EN
        if (irq_done) begin
          if (depth != 2'd0) depth_nxt = depth - 2'd1;
          if (depth <= 2'd1) state_nxt = IDLE;
        end else if (nmi_pend && !sel_is_nmi && (depth == 2'd1)) begin
          sel_nxt   = NMI_IDX;
          latch     = 1'b1;
          state_nxt = REQ;
        end
`else
        if (irq_done) state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Edge history, sticky flags and mask register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_in_q <= '0;
      flags    <= '0;
      mask     <= '0;
    end else if (clk_en) begin
      irq_in_q <= irq_in;
      flags    <= (flags & ~clr_vec) | set_vec;
      if (mask_wr_en) mask <= mask_wr_data;
    end
  end

  // FSM state, selected channel and latched vector
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sel        <= '0;
      irq_vector <= '0;
    end else if (clk_en) begin
      state <= state_nxt;
      sel   <= sel_nxt;
      if (latch) irq_vector <= VEC_W'(sel_nxt) + VEC_W'(VECTOR_BASE);
    end
  end

`ifdef IRQ_CONTROLLER_NMI_EN
  // Count of taken, not yet completed requests
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     depth <= 2'd0;
    else if (clk_en)  depth <= depth_nxt;
  end

  // Outputs decoded from state; busy also covers a nested request phase
  always_comb begin
    irq_valid = (state == REQ);
    busy      = (state == BUSY) || (depth != 2'd0);
  end
`else
  // Outputs decoded from state
  always_comb begin
    irq_valid = (state == REQ);
    busy      = (state == BUSY);
  end
`endif

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: scenario-driven bench for irq_controller (default
// parameters). Expected vectors are queued when a request is stimulated and
// popped when irq_valid appears.
module tb_irq_controller;

  localparam int NUM_IRQ     = 15;
  localparam int VECTOR_BASE = 1;
  localparam int VEC_W       = 4;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               clk_en;
  logic [NUM_IRQ-1:0] irq_in;
  logic               mask_wr_en;
  logic [NUM_IRQ-1:0] mask_wr_data;
  logic               flag_clr_en;
  logic [NUM_IRQ-1:0] flag_clr_data;
  logic               global_enable;
  logic               irq_ack;
  logic               irq_done;
  logic               irq_valid;
  logic [VEC_W-1:0]   irq_vector;
  logic [NUM_IRQ-1:0] flags;
  logic [NUM_IRQ-1:0] mask;
  logic               busy;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [VEC_W-1:0] exp_q[$];
  logic [VEC_W-1:0] exp_v;
  bit               ok;

  always #5 clk = ~clk;

  irq_controller #(.NUM_IRQ(NUM_IRQ), .VECTOR_BASE(VECTOR_BASE)) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .irq_in(irq_in),
    .mask_wr_en(mask_wr_en), .mask_wr_data(mask_wr_data),
    .flag_clr_en(flag_clr_en), .flag_clr_data(flag_clr_data),
    .global_enable(global_enable), .irq_ack(irq_ack), .irq_done(irq_done),
    .irq_valid(irq_valid), .irq_vector(irq_vector), .flags(flags),
    .mask(mask), .busy(busy)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // bounded wait for irq_valid, sampled on falling edges
  task automatic wait_valid(input int max_cyc, output bit seen);
    int n;
    seen = irq_valid;
    n = 0;
    while (!seen && n < max_cyc) begin
      @(negedge clk);
      n++;
      seen = irq_valid;
    end
  endtask

  task automatic write_mask(input logic [NUM_IRQ-1:0] m);
    mask_wr_en = 1'b1; mask_wr_data = m; step(1);
    mask_wr_en = 1'b0;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
  endtask

  task automatic pulse_done();
    irq_done = 1'b1; step(1); irq_done = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clk_en = 1'b1; irq_in = '0; mask_wr_en = 1'b0;
    mask_wr_data = '0; flag_clr_en = 1'b0; flag_clr_data = '0;
    global_enable = 1'b0; irq_ack = 1'b0; irq_done = 1'b0;
    step(2);
    total_cnt++;
    if ({irq_valid, irq_vector, flags, mask, busy} !== '0)
      $display("FAIL reset: valid=%0b vec=%0d flags=%h mask=%h busy=%0b, required all 0",
               irq_valid, irq_vector, flags, mask, busy);
    else pass_cnt++;
    reset_n = 1'b1; step(1);
  endtask

  task automatic test_basic();
    global_enable = 1'b1;
    write_mask(15'h0003);
    irq_in[1] = 1'b1; exp_q.push_back(4'd2); step(1);
    irq_in[1] = 1'b0;
    total_cnt++;
    if (flags !== 15'h0002 || irq_valid !== 1'b0)
      $display("FAIL basic_flag: flags=%h valid=%0b, required 0002/0", flags, irq_valid);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (irq_valid !== 1'b1 || exp_q.size() == 0)
      $display("FAIL basic_valid: valid=%0b, required 1", irq_valid);
    else begin
      exp_v = exp_q.pop_front();
      if (irq_vector !== exp_v) $display("FAIL basic_vec: vec=%0d, required %0d", irq_vector, exp_v);
      else pass_cnt++;
    end
    pulse_ack();
    total_cnt++;
    if (flags !== 15'h0000 || busy !== 1'b1 || irq_valid !== 1'b0)
      $display("FAIL basic_ack: flags=%h busy=%0b valid=%0b, required 0000/1/0", flags, busy, irq_valid);
    else pass_cnt++;
    pulse_done();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL basic_done: busy=%0b, required 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_priority();
    write_mask(15'h7FFF);
    irq_in[4] = 1'b1; irq_in[2] = 1'b1;
    exp_q.push_back(4'd3); exp_q.push_back(4'd5);
    step(1);
    irq_in = '0;
    for (int k = 0; k < 2; k++) begin
      wait_valid(6, ok);
      total_cnt++;
      if (!ok || exp_q.size() == 0) $display("FAIL prio_valid%0d: valid=%0b, required 1", k, irq_valid);
      else begin
        exp_v = exp_q.pop_front();
        if (irq_vector !== exp_v) $display("FAIL prio_vec%0d: vec=%0d, required %0d", k, irq_vector, exp_v);
        else pass_cnt++;
      end
      if (k == 1) begin
        total_cnt++;
        if (flags !== 15'h0010) $display("FAIL prio_flags: flags=%h, required 0010", flags);
        else pass_cnt++;
      end
      pulse_ack();
      pulse_done();
    end
    total_cnt++;
    if (flags !== 15'h0000) $display("FAIL prio_clear: flags=%h, required 0000", flags);
    else pass_cnt++;
  endtask

  task automatic test_level_mask();
    bit saw_valid;
    write_mask(15'h0000);
    saw_valid = 1'b0;
    irq_in[3] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (irq_valid) saw_valid = 1'b1;
    end
    irq_in[3] = 1'b0;
    total_cnt++;
    if (flags !== 15'h0008 || saw_valid !== 1'b0)
      $display("FAIL level_masked: flags=%h saw_valid=%0b, required 0008/0", flags, saw_valid);
    else pass_cnt++;
    exp_q.push_back(4'd4);
    write_mask(15'h0008);
    wait_valid(2, ok);
    total_cnt++;
    if (!ok || exp_q.size() == 0) $display("FAIL unmask_valid: valid=%0b, required 1", irq_valid);
    else begin
      exp_v = exp_q.pop_front();
      if (irq_vector !== exp_v) $display("FAIL unmask_vec: vec=%0d, required %0d", irq_vector, exp_v);
      else pass_cnt++;
    end
    pulse_ack();
    pulse_done();
  endtask

  task automatic test_withdraw();
    write_mask(15'h0001);
    irq_in[0] = 1'b1; exp_q.push_back(4'd1); step(1);
    irq_in[0] = 1'b0;
    wait_valid(4, ok);
    total_cnt++;
    if (!ok || exp_q.size() == 0) $display("FAIL wd_valid: valid=%0b, required 1", irq_valid);
    else begin
      exp_v = exp_q.pop_front();
      if (irq_vector !== exp_v) $display("FAIL wd_vec: vec=%0d, required %0d", irq_vector, exp_v);
      else pass_cnt++;
    end
    flag_clr_en = 1'b1; flag_clr_data = 15'h0001; step(1);
    flag_clr_en = 1'b0; flag_clr_data = '0;
    step(1);
    total_cnt++;
    if (irq_valid !== 1'b0 || busy !== 1'b0 || flags !== 15'h0000)
      $display("FAIL wd_drop: valid=%0b busy=%0b flags=%h, required 0/0/0000", irq_valid, busy, flags);
    else pass_cnt++;
    // set beats clear on the same bit
    write_mask(15'h0000);
    irq_in[0] = 1'b1; step(1); irq_in[0] = 1'b0; step(1);
    irq_in[0] = 1'b1; flag_clr_en = 1'b1; flag_clr_data = 15'h0001; step(1);
    irq_in[0] = 1'b0; flag_clr_en = 1'b0; flag_clr_data = '0;
    total_cnt++;
    if (flags[0] !== 1'b1) $display("FAIL set_wins: flags[0]=%0b, required 1", flags[0]);
    else pass_cnt++;
    flag_clr_en = 1'b1; flag_clr_data = 15'h0001; step(1);
    flag_clr_en = 1'b0; flag_clr_data = '0;
    total_cnt++;
    if (flags !== 15'h0000) $display("FAIL sw_clear: flags=%h, required 0000", flags);
    else pass_cnt++;
  endtask

  task automatic test_clk_en_reset();
    write_mask(15'h0020);
    clk_en = 1'b0;
    irq_in[5] = 1'b1; step(2);
    irq_in[5] = 1'b0; step(1);
    clk_en = 1'b1; step(3);
    total_cnt++;
    if (flags !== 15'h0000 || irq_valid !== 1'b0)
      $display("FAIL clk_en_hold: flags=%h valid=%0b, required 0000/0", flags, irq_valid);
    else pass_cnt++;
    write_mask(15'h0040);
    irq_in[6] = 1'b1; exp_q.push_back(4'd7); step(1);
    irq_in[6] = 1'b0;
    wait_valid(4, ok);
    total_cnt++;
    if (!ok || exp_q.size() == 0) $display("FAIL ar_valid: valid=%0b, required 1", irq_valid);
    else begin
      exp_v = exp_q.pop_front();
      if (irq_vector !== exp_v) $display("FAIL ar_vec: vec=%0d, required %0d", irq_vector, exp_v);
      else pass_cnt++;
    end
    pulse_ack();
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL ar_busy: busy=%0b, required 1", busy);
    else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({irq_valid, irq_vector, flags, mask, busy} !== '0)
      $display("FAIL async_reset: valid=%0b vec=%0d flags=%h mask=%h busy=%0b, required all 0",
               irq_valid, irq_vector, flags, mask, busy);
    else pass_cnt++;
    @(negedge clk); reset_n = 1'b1; step(1);
  endtask

`ifdef IRQ_CONTROLLER_NMI_EN
  task automatic test_nmi();
    global_enable = 1'b0;
    write_mask(15'h0000);
    irq_in[14] = 1'b1; exp_q.push_back(4'd15); step(1);
    irq_in[14] = 1'b0;
    wait_valid(4, ok);
    total_cnt++;
    if (!ok || exp_q.size() == 0) $display("FAIL nmi_valid: valid=%0b, required 1", irq_valid);
    else begin
      exp_v = exp_q.pop_front();
      if (irq_vector !== exp_v) $display("FAIL nmi_vec: vec=%0d, required %0d", irq_vector, exp_v);
      else pass_cnt++;
    end
    pulse_ack(); pulse_done();
    global_enable = 1'b1;
    write_mask(15'h0004);
    irq_in[2] = 1'b1; exp_q.push_back(4'd3); step(1);
    irq_in[2] = 1'b0;
    wait_valid(4, ok);
    total_cnt++;
    if (!ok || exp_q.size() == 0) $display("FAIL nest_valid: valid=%0b, required 1", irq_valid);
    else begin
      exp_v = exp_q.pop_front();
      if (irq_vector !== exp_v) $display("FAIL nest_vec: vec=%0d, required %0d", irq_vector, exp_v);
      else pass_cnt++;
    end
    pulse_ack();
    irq_in[14] = 1'b1; exp_q.push_back(4'd15); step(1);
    irq_in[14] = 1'b0;
    wait_valid(4, ok);
    total_cnt++;
    if (!ok || exp_q.size() == 0 || busy !== 1'b1) $display("FAIL nest_nmi_valid: valid=%0b busy=%0b, required 1/1", irq_valid, busy);
    else begin
      exp_v = exp_q.pop_front();
      if (irq_vector !== exp_v) $display("FAIL nest_nmi_vec: vec=%0d, required %0d", irq_vector, exp_v);
      else pass_cnt++;
    end
    pulse_ack();
    pulse_done();
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL nest_done1: busy=%0b, required 1", busy);
    else pass_cnt++;
    pulse_done();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL nest_done2: busy=%0b, required 0", busy);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_level_mask();
    test_withdraw();
    test_clk_en_reset();
`ifdef IRQ_CONTROLLER_NMI_EN
    test_nmi();
`endif
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_empty: left=%0d, required 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
